// File: rtl/imem_boot_loader_if.sv
// Byte-stream and instruction-memory write bundle for the boot loader.
// The master side is whoever feeds the image (and observes the result); the
// slave side is the loader itself.
interface imem_boot_loader_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             imem_we;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_wdata;
  logic             start;
  logic             busy;
  logic             error;
  logic [CNT_W-1:0] words_loaded;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata,
           start, busy, error, words_loaded
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata,
           start, busy, error, words_loaded
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot front-end for the single-cycle RISC-V core.
// Takes a byte stream of the form: count (16-bit LE words) | payload words,
// least-significant byte first | one XOR checksum byte over the payload.
// Each assembled word is written to instruction memory, and once the
// checksum matches, start is raised to release the core. Any failure parks
// the loader in a sticky error state with start held low.
module imem_boot_loader #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          CNT_W      = 16
) (
  input logic clk,
  input logic rst,
  imem_boot_loader_if.slave bus
);

  typedef enum logic [2:0] {
    CNT_LO,
    CNT_HI,
    DATA,
    CHECK,
    DONE,
    ERR
  } state_t;

  state_t           state_q;
  logic             inReady_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             start_q;
  logic             busy_q;
  logic             error_q;
  logic [CNT_W-1:0] wordsLoaded_q;
  logic [CNT_W-1:0] count_q;
  logic [1:0]       byteIdx_q;
  logic [23:0]      partial_q;
  logic [7:0]       csum_q;

  logic             accept;
  logic [15:0]      headerCount;
  logic [CNT_W-1:0] nextWords;

  // A byte moves only when offered and the loader is in a receiving state.
  assign accept      = bus.in_valid & inReady_q;
  // Full word count as it will stand once the high header byte is taken.
  assign headerCount = {bus.in_data, count_q[7:0]};
  assign nextWords   = wordsLoaded_q + CNT_W'(1);

  // Loader state machine; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= CNT_LO;
      inReady_q     <= 1'b1;
      we_q          <= 1'b0;
      addr_q        <= BASE_ADDR;
      wdata_q       <= 32'h0;
      start_q       <= 1'b0;
      busy_q        <= 1'b0;
      error_q       <= 1'b0;
      wordsLoaded_q <= '0;
      count_q       <= '0;
      byteIdx_q     <= 2'd0;
      partial_q     <= 24'h0;
      csum_q        <= 8'h0;
    end else begin
      we_q <= 1'b0;
      if (accept) begin
        case (state_q)
          CNT_LO: begin
            count_q[7:0] <= bus.in_data;
            busy_q       <= 1'b1;
            state_q      <= CNT_HI;
          end
          CNT_HI: begin
            count_q <= CNT_W'(headerCount);
            if (32'(headerCount) > IMEM_WORDS) begin
              state_q   <= ERR;
              error_q   <= 1'b1;
              busy_q    <= 1'b0;
              inReady_q <= 1'b0;
            end else if (headerCount == 16'd0) begin
              state_q <= CHECK;
            end else begin
              state_q <= DATA;
            end
          end
          DATA: begin
            csum_q    <= csum_q ^ bus.in_data;
            partial_q <= {bus.in_data, partial_q[23:8]};
            byteIdx_q <= byteIdx_q + 2'd1;
            if (byteIdx_q == 2'd3) begin
              we_q          <= 1'b1;
              wdata_q       <= {bus.in_data, partial_q};
              addr_q        <= BASE_ADDR + (32'(wordsLoaded_q) << 2);
              wordsLoaded_q <= nextWords;
              if (nextWords == count_q) begin
                state_q <= CHECK;
              end
            end
          end
          CHECK: begin
            busy_q    <= 1'b0;
            inReady_q <= 1'b0;
            if (bus.in_data == csum_q) begin
              state_q <= DONE;
              start_q <= 1'b1;
            end else begin
              state_q <= ERR;
              error_q <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.in_ready     = inReady_q;
  assign bus.imem_we      = we_q;
  assign bus.imem_addr    = addr_q;
  assign bus.imem_wdata   = wdata_q;
  assign bus.start        = start_q;
  assign bus.busy         = busy_q;
  assign bus.error        = error_q;
  assign bus.words_loaded = wordsLoaded_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: streams directed and random images, predicts
// writes and final status from an image-level model, and checks write
// strobes through a scoreboard drained by an independent monitor.
module tb_imem_boot_loader;

  localparam int          IMEM_WORDS = 256;
  localparam int          CNT_W      = 16;
  localparam logic [31:0] BASE_ADDR  = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  imem_boot_loader_if #(.CNT_W(CNT_W)) bus ();

  imem_boot_loader #(
    .IMEM_WORDS(IMEM_WORDS),
    .BASE_ADDR (BASE_ADDR),
    .CNT_W     (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  int         compares = 0;
  int         failures = 0;
  wr_t        sbQueue[$];
  wr_t        modelWrites[$];
  logic [7:0] img[$];
  int         modelN;
  int         nAccept;
  logic       expStart;
  logic       expErr;
  int         expWords;
  logic       prevWe = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    compares++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  // Image-level reference: header count, LE word assembly, payload XOR.
  function automatic void buildModel();
    logic [7:0] cs;
    modelWrites.delete();
    modelN = int'({img[1], img[0]});
    cs = 8'h00;
    if (modelN > IMEM_WORDS) begin
      nAccept  = 2;
      expWords = 0;
      expStart = 1'b0;
      expErr   = 1'b1;
      return;
    end
    for (int k = 0; k < modelN; k++) begin
      wr_t w;
      w.addr = BASE_ADDR + 32'(4 * k);
      w.data = {img[2+4*k+3], img[2+4*k+2], img[2+4*k+1], img[2+4*k]};
      modelWrites.push_back(w);
      for (int b = 0; b < 4; b++) cs ^= img[2+4*k+b];
    end
    nAccept  = 2 + 4 * modelN + 1;
    expWords = modelN;
    expStart = (img[2+4*modelN] == cs);
    expErr   = !expStart;
  endfunction

  // Random image of n words; corrupt flips one bit of the checksum byte.
  function automatic void makeImage(input int n, input bit corrupt);
    logic [7:0] cs;
    logic [7:0] b;
    logic [15:0] n16;
    n16 = 16'(n);
    img.delete();
    img.push_back(n16[7:0]);
    img.push_back(n16[15:8]);
    cs = 8'h00;
    if (n > IMEM_WORDS) return;
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      img.push_back(b);
      cs ^= b;
    end
    if (corrupt) cs ^= 8'(1 << $urandom_range(7, 0));
    img.push_back(cs);
  endfunction

  task automatic checkReset(input string tag);
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, ".imem_we"}, 32'(bus.imem_we), 32'd0);
    check({tag, ".imem_addr"}, bus.imem_addr, BASE_ADDR);
    check({tag, ".imem_wdata"}, bus.imem_wdata, 32'h0);
    check({tag, ".start"}, 32'(bus.start), 32'd0);
    check({tag, ".busy"}, 32'(bus.busy), 32'd0);
    check({tag, ".error"}, 32'(bus.error), 32'd0);
    check({tag, ".words_loaded"}, 32'(bus.words_loaded), 32'd0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkReset("reset");
    rst = 1'b0;
  endtask

  // Offer one byte and return on the negedge after it has been accepted.
  task automatic sendByte(input logic [7:0] b);
    int waited;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    waited = 0;
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      check("acceptTimeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    repeat (6) @(negedge clk);
    check({tag, ".pendingWrites"}, 32'(sbQueue.size()), 32'd0);
    check({tag, ".words_loaded"}, 32'(bus.words_loaded), 32'(expWords));
    check({tag, ".start"}, 32'(bus.start), 32'(expStart));
    check({tag, ".error"}, 32'(bus.error), 32'(expErr));
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, ".busy"}, 32'(bus.busy), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'($urandom);
    repeat (4) @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, ".holdWords"}, 32'(bus.words_loaded), 32'(expWords));
    check({tag, ".holdStart"}, 32'(bus.start), 32'(expStart));
  endtask

  // Stream the current image; abortAfter >= 0 resets before that byte index.
  task automatic applyStimulus(input string tag, input bit doReset, input int maxGap,
                               input int gapAt, input int gapLen, input int abortAfter);
    int g;
    if (doReset) pulseReset();
    buildModel();
    for (int i = 0; i < nAccept; i++) begin
      if (i == abortAfter) begin
        #2 rst = 1'b1;
        #1 checkReset({tag, ".abort"});
        sbQueue.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      g = (i == gapAt) ? gapLen : ((maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0);
      bus.in_valid = 1'b0;
      repeat (g) begin
        bus.in_data = 8'($urandom);
        @(negedge clk);
      end
      if (i >= 2 && i < 2 + 4 * modelN && ((i - 2) % 4) == 3)
        sbQueue.push_back(modelWrites[(i-2)/4]);
      if (i == nAccept - 1) begin
        check({tag, ".startBeforeLast"}, 32'(bus.start), 32'd0);
        check({tag, ".errorBeforeLast"}, 32'(bus.error), 32'd0);
      end
      sendByte(img[i]);
    end
    check({tag, ".startAfterLast"}, 32'(bus.start), 32'(expStart));
    check({tag, ".errorAfterLast"}, 32'(bus.error), 32'(expErr));
    checkOutput(tag);
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.imem_we) begin
        check("strobeWidth", 32'(prevWe), 32'd0);
        if (sbQueue.size() == 0) begin
          compares++;
          failures++;
          $display("[TB] FAIL unexpectedStrobe actual=%h/%h required=none",
                   bus.imem_addr, bus.imem_wdata);
        end else begin
          wr_t e;
          e = sbQueue.pop_front();
          check("strobeAddr", bus.imem_addr, e.addr);
          check("strobeData", bus.imem_wdata, e.data);
        end
      end
      prevWe = bus.imem_we;
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] time limit reached");
  end

  // Directed scenarios followed by randomized images.
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00, 8'hB0};
    applyStimulus("twoWords", 1'b1, 0, -1, 0, -1);

    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00, 8'h81};
    applyStimulus("badCsum", 1'b1, 0, -1, 0, -1);

    img = '{8'h00, 8'h00, 8'h00};
    applyStimulus("empty", 1'b1, 0, -1, 0, -1);

    img = '{8'h01, 8'h01};
    applyStimulus("tooLong", 1'b1, 0, -1, 0, -1);

    img = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    applyStimulus("gapWord", 1'b1, 0, 4, 5, -1);

    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00, 8'hB0};
    applyStimulus("abort", 1'b1, 0, -1, 0, 8);
    applyStimulus("replay", 1'b0, 0, -1, 0, -1);

    makeImage(IMEM_WORDS, 1'b0);
    applyStimulus("fullImem", 1'b1, 0, -1, 0, -1);

    makeImage(16'hFFFF, 1'b0);
    applyStimulus("maxCount", 1'b1, 0, -1, 0, -1);

    for (int r = 0; r < 12; r++) begin
      makeImage(int'($urandom_range(8, 1)), ($urandom_range(3, 0) == 0));
      applyStimulus($sformatf("rand%0d", r), 1'b1, 2, -1, 0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", compares, failures);
    $finish;
  end

endmodule
